// File: rtl/rng_address_scheduler_pkg.sv
// Shared definitions for the random address scheduler: FSM encoding,
// LFSR polynomial, default seed and small LFSR helpers.
package rng_address_scheduler_pkg;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REARM = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    // One Galois step, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [15:0] safe_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/rng_address_scheduler_lfsr.sv
// 16-bit free-running Galois LFSR with synchronous active-low reload of seed.
module rng_lfsr16
    import rng_address_scheduler_pkg::*;
(
    input  logic        clock,
    input  logic        nrst,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Advance every non-reset cycle; reload the (sanitised) seed in reset.
    always_comb begin
        value_d = nrst ? lfsr_step(value_q) : safe_seed(seed);
    end

    // LFSR state register.
    always_ff @(posedge clock) begin
        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/rng_address_scheduler.sv
// Round-robin scheduler that serves requesters with a pseudo-random address
// (LFSR value mod the requester's count) using an external modulo unit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate; latch requester id and its count
// REARM | pulse rng_nrst low to clear the sticky done; capture LFSR in which
// START | one-cycle start pulse to the modulo unit
// WAIT  | wait for done_rng_address, then capture the remainder
// RESP  | resp_valid and ack[id] high; remember id as last grant
module rng_address_scheduler
    import rng_address_scheduler_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic                 clock,
    input  logic                 nrst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   count,
    output logic [NREQ-1:0]      ack,
    output logic                 resp_valid,
    output logic [2:0]           resp_id,
    output logic [15:0]          resp_addr,
    output logic                 resp_err,
    output logic                 rng_nrst,
    output logic                 start_rng_address,
    output logic [15:0]          which,
    output logic [15:0]          betterNeighborCount,
    input  logic [15:0]          rng_address,
    input  logic                 done_rng_address
);

    localparam logic [2:0] LAST_GRANT_RST = 3'(NREQ - 1);

    sched_state_t state_q, state_d;

    logic [2:0]      last_grant_q, last_grant_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [15:0]     bnc_q, bnc_d;
    logic [15:0]     which_q, which_d;
    logic [2:0]      resp_id_q, resp_id_d;
    logic [15:0]     resp_addr_q, resp_addr_d;
    logic            resp_err_q, resp_err_d;
    logic            resp_valid_q, resp_valid_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            start_q, start_d;

    logic            arb_found;
    logic [2:0]      arb_id;
    logic [15:0]     arb_count;
    int              arb_idx;

    logic [15:0]     lfsr_value;

    rng_lfsr16 u_lfsr (
        .clock (clock),
        .nrst  (nrst),
        .seed  (SEED),
        .value (lfsr_value)
    );

    // Round-robin search starting just after the last served requester.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = 3'd0;
        arb_count = 16'h0000;
        arb_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_idx = (int'(last_grant_q) + k) % NREQ;
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = 3'(arb_idx);
                arb_count = count[arb_idx*16 +: 16];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        state_q <= state_d;
    end

    // Next-state logic; a zero count skips the modulo unit entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = (arb_count == 16'h0000) ? RESP : REARM;
                end
            end
            REARM:   state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (done_rng_address) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!nrst) begin
            state_d = IDLE;
        end
    end

    // Output and datapath next values, timed so pulses line up with their state.
    always_comb begin
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        bnc_d        = bnc_q;
        which_d      = which_q;
        resp_id_d    = resp_id_q;
        resp_addr_d  = resp_addr_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = 1'b0;
        ack_d        = '0;
        start_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_id_d = arb_id;
                    bnc_d      = arb_count;
                    if (arb_count == 16'h0000) begin
                        resp_id_d    = arb_id;
                        resp_addr_d  = 16'h0000;
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        ack_d        = NREQ'(1) << arb_id;
                    end
                end
            end
            REARM: begin
                which_d = lfsr_value;
                start_d = 1'b1;
            end
            WAIT: begin
                if (done_rng_address) begin
                    resp_id_d    = grant_id_q;
                    resp_addr_d  = rng_address;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    ack_d        = NREQ'(1) << grant_id_q;
                end
            end
            RESP: begin
                last_grant_d = grant_id_q;
            end
            default: ;
        endcase
        if (!nrst) begin
            last_grant_d = LAST_GRANT_RST;
            grant_id_d   = 3'd0;
            bnc_d        = 16'h0000;
            which_d      = 16'h0000;
            resp_id_d    = 3'd0;
            resp_addr_d  = 16'h0000;
            resp_err_d   = 1'b0;
            resp_valid_d = 1'b0;
            ack_d        = '0;
            start_d      = 1'b0;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clock) begin
        last_grant_q <= last_grant_d;
        grant_id_q   <= grant_id_d;
        bnc_q        <= bnc_d;
        which_q      <= which_d;
        resp_id_q    <= resp_id_d;
        resp_addr_q  <= resp_addr_d;
        resp_err_q   <= resp_err_d;
        resp_valid_q <= resp_valid_d;
        ack_q        <= ack_d;
        start_q      <= start_d;
    end

    // The modulo unit follows our reset and is re-armed once per request.
    assign rng_nrst            = nrst && (state_q != REARM);
    assign start_rng_address   = start_q;
    assign which               = which_q;
    assign betterNeighborCount = bnc_q;
    assign resp_id             = resp_id_q;
    assign resp_addr           = resp_addr_q;
    assign resp_err            = resp_err_q;
    assign resp_valid          = resp_valid_q;
    assign ack                 = ack_q;

endmodule

// File: doc/rng_address_scheduler.md
RNG_ADDRESS_SCHEDULER -- requirements
Module: rng_address_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter SEED, default 16'hACE1, giving the LFSR reset value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-003 The block SHALL have port clock, input, 1 bit, the system clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port nrst, input, 1 bit, a synchronous, active-low reset.
REQ-005 The block SHALL have port req, input, NREQ bits, a per-requester request level.
REQ-006 The block SHALL have port count, input, 16*NREQ bits, the per-requester betterNeighborCount, with slice i = count[16i+15:16i].
REQ-007 The block SHALL have port ack, output, NREQ bits, a one-hot one-cycle completion pulse.
REQ-008 The block SHALL have port resp_valid, output, 1 bit, a one-cycle response strobe.
REQ-009 The block SHALL have port resp_id, output, 3 bits, the index of the requester being served.
REQ-010 The block SHALL have port resp_addr, output, 16 bits, the selected address (which mod count).
REQ-011 The block SHALL have port resp_err, output, 1 bit, asserted when the served count was 0.
REQ-012 The block SHALL have port rng_nrst, output, 1 bit, the synchronous active-low reset to the modulo unit.
REQ-013 The block SHALL have port start_rng_address, output, 1 bit, the start pulse to the modulo unit.
REQ-014 The block SHALL have port which, output, 16 bits, the dividend driven to the modulo unit.
REQ-015 The block SHALL have port betterNeighborCount, output, 16 bits, the divisor driven to the modulo unit.
REQ-016 The block SHALL have port rng_address, input, 16 bits, the remainder from the modulo unit.
REQ-017 The block SHALL have port done_rng_address, input, 1 bit, the modulo-unit done flag, which is sticky until that unit is reset.

Function
REQ-018 A 16-bit Galois LFSR SHALL advance every non-reset cycle as lfsr = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
REQ-019 The FSM SHALL use the states IDLE, REARM, START, WAIT and RESP.
REQ-020 In IDLE with any req bit set, the block SHALL grant round-robin, searching from (last_grant+1) mod NREQ, and SHALL latch the index and the count slice.
REQ-021 From IDLE, if the latched count is 0 the FSM SHALL go directly to RESP with resp_err=1 and resp_addr=0, and SHALL NOT touch the modulo unit.
REQ-022 From IDLE, if the latched count is non-zero the FSM SHALL go to REARM.
REQ-023 In REARM, rng_nrst SHALL be 0 for exactly one cycle, clearing the sticky done flag.
REQ-024 In REARM, the current LFSR value SHALL be registered into which, and the FSM SHALL go to START.
REQ-025 In START, start_rng_address SHALL be 1 for exactly one cycle, and the FSM SHALL go to WAIT.
REQ-026 In WAIT, the FSM SHALL stay while done_rng_address=0; the first cycle it is 1, rng_address SHALL be latched into resp_addr and the FSM SHALL go to RESP.
REQ-027 WAIT SHALL have no timeout, since the worst case is about 65536 cycles (count=1, which=16'hFFFF).
REQ-028 In RESP, resp_valid=1 and ack[id]=1 SHALL be asserted for one cycle, last_grant SHALL be set to id, and the FSM SHALL go to IDLE.
REQ-029 which and betterNeighborCount SHALL remain stable from REARM through WAIT.
REQ-030 resp_id, resp_addr and resp_err SHALL hold their values until the next RESP.
REQ-031 Minimum latency from req to resp_valid SHALL be 4 cycles plus the modulo-unit run time; the zero-count path SHALL take 2 cycles.
REQ-032 Changes to req or count after the grant SHALL be ignored until the next IDLE.
REQ-033 A requester that keeps req high after ack SHALL be re-arbitrated; it SHALL NOT be served again while another requester is pending.
REQ-034 rng_nrst SHALL equal 0 whenever nrst=0, and 1 outside REARM.
REQ-035 A done_rng_address=1 seen outside WAIT SHALL be ignored.

Reset
REQ-036 When nrst=0 at a clock edge, the FSM SHALL go to IDLE and the LFSR SHALL be loaded with SEED (or 1 if SEED is 0).
REQ-037 Reset SHALL set last_grant=NREQ-1, so that requester 0 wins first.
REQ-038 Reset SHALL clear ack, resp_valid, resp_id, resp_addr, resp_err, start_rng_address, which and betterNeighborCount to 0.
REQ-039 A reset mid-operation SHALL abort without a response, and the modulo unit SHALL be reset with it through rng_nrst.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding (3-bit), the LFSR_TAPS = 16'hB400 constant and the default seed.
REQ-041 One sub-module, rng_lfsr16, SHALL implement the LFSR, with ports clock, nrst, seed and value.
REQ-042 The modulo unit SHALL be instantiated outside this block; the bench SHALL instantiate it beside the DUT.

Verification
REQ-043 With SEED=16'hACE1 and no requests, the bench SHALL see LFSR values ACE1, E270, 7138 on successive cycles.
REQ-044 With req=4'b0001 and count0=5, the bench SHALL see resp_id=0, resp_addr equal to which mod 5, resp_err=0, and ack=0001 coincident with resp_valid.
REQ-045 With req=4'b0100 and count2=0, the bench SHALL see resp_err=1 and resp_addr=0 two cycles later, with no start_rng_address pulse.
REQ-046 With req=4'b1111 held high and all counts 3, the bench SHALL see grants in order 0,1,2,3,0.
REQ-047 With count=1, the bench SHALL see resp_addr=0 for all which values, including a SEED forcing which=16'hFFFF, and no hang.
REQ-048 Asserting nrst=0 in WAIT SHALL give FSM IDLE, rng_nrst=0 and no resp_valid; a new request after reset SHALL complete correctly.
